// File: rtl/bean_pkg.sv
// Shared map geometry and scan-state encoding for the bean occupancy map.
// Used by both the map writer and the bean_render reader.
package bean_pkg;

  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int TILE_PX  = 16;
  localparam int MAP_BITS = 1200;
  localparam int IDX_W    = 11;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/bean_scan.sv
// Background popcount of the live bean map, one bit per cycle, started by frame_start.
//   state | meaning
//   IDLE  | waiting for frame_start
//   SCAN  | adding beans[ptr] into acc, ptr walks 0..1199
//   DONE  | publishing acc to remaining / cnt_valid / all_clear
module bean_scan
  import bean_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MAP_BITS-1:0] beans,
  input  logic                frame_start,
  output logic [IDX_W-1:0]    remaining,
  output logic                cnt_valid,
  output logic                all_clear,
  output logic                busy
);

  scan_state_t      state, state_nx;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      acc       <= '0;
      remaining <= '0;
      cnt_valid <= 1'b0;
      all_clear <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (frame_start) begin
            ptr <= '0;
            acc <= '0;
          end
        end
        SCAN: begin
          acc <= acc + {{(IDX_W-1){1'b0}}, beans[ptr]};
          ptr <= ptr + 1'b1;
        end
        DONE: begin
          remaining <= acc;
          cnt_valid <= 1'b1;
          all_clear <= (acc == '0);
        end
        default: ;
      endcase
    end
  end

  // frame_start outside IDLE is dropped, not queued
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = SCAN;
      SCAN:    if (ptr == IDX_W'(MAP_BITS - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/bean_render.sv
// Bean map reader: 3-stage pixel pipeline producing the bean-dot colour, plus
// the background remaining-bean counter.
module bean_render
  import bean_pkg::*;
#(
  parameter int          BEAN_R2  = 9,
  parameter logic [11:0] BEAN_RGB = 12'hFF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAP_BITS-1:0] beans,
  input  logic [9:0]          pix_x,
  input  logic [8:0]          pix_y,
  input  logic                pix_valid,
  input  logic                frame_start,
  output logic                bean_on,
  output logic [11:0]         bean_rgb,
  output logic                pix_valid_o,
  output logic [IDX_W-1:0]    remaining,
  output logic                cnt_valid,
  output logic                all_clear,
  output logic                busy
);

  logic [5:0]        s1_col;
  logic [4:0]        s1_row;
  logic [3:0]        s1_ox, s1_oy;
  logic              s1_in, s1_vld;
  logic [IDX_W-1:0]  s2_idx;
  logic signed [4:0] s2_dx, s2_dy;
  logic              s2_in, s2_vld;
  logic [4:0]        dx_neg, dy_neg;
  logic [3:0]        dx_mag, dy_mag;
  logic [7:0]        dist2;
  logic              bean_bit;

  // |-8| wraps to 5'b01000, so the low 4 bits still hold the magnitude 8
  assign dx_neg   = -s2_dx;
  assign dy_neg   = -s2_dy;
  assign dx_mag   = s2_dx[4] ? dx_neg[3:0] : s2_dx[3:0];
  assign dy_mag   = s2_dy[4] ? dy_neg[3:0] : s2_dy[3:0];
  assign dist2    = 8'(dx_mag * dx_mag) + 8'(dy_mag * dy_mag);
  assign bean_bit = (s2_idx < IDX_W'(MAP_BITS)) ? beans[s2_idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_in       <= 1'b0;
      s1_vld      <= 1'b0;
      s2_in       <= 1'b0;
      s2_vld      <= 1'b0;
      bean_on     <= 1'b0;
      bean_rgb    <= '0;
      pix_valid_o <= 1'b0;
    end else begin
      s1_col <= pix_x[9:4];
      s1_row <= pix_y[8:4];
      s1_ox  <= pix_x[3:0];
      s1_oy  <= pix_y[3:0];
      s1_in  <= pix_valid & (pix_x < 10'(SCR_W)) & (pix_y < 9'(SCR_H));
      s1_vld <= pix_valid;

      s2_idx <= IDX_W'({s1_row, 5'b0}) + IDX_W'({s1_row, 3'b0}) + IDX_W'(s1_col);
      s2_dx  <= $signed({1'b0, s1_ox}) - 5'sd8;
      s2_dy  <= $signed({1'b0, s1_oy}) - 5'sd8;
      s2_in  <= s1_in;
      s2_vld <= s1_vld;

      // beans is sampled here so writer clears show up on the very next pixel
      bean_on     <= s2_in & bean_bit & (dist2 <= 8'(BEAN_R2));
      bean_rgb    <= (s2_in & bean_bit & (dist2 <= 8'(BEAN_R2))) ? BEAN_RGB : 12'h000;
      pix_valid_o <= s2_vld;
    end
  end

  bean_scan u_scan (
    .clk         (clk),
    .rst         (rst),
    .beans       (beans),
    .frame_start (frame_start),
    .remaining   (remaining),
    .cnt_valid   (cnt_valid),
    .all_clear   (all_clear),
    .busy        (busy)
  );

endmodule

// File: tb/tb_bean_render.sv
// Scoreboard bench for bean_render: pixel and scan expectations are queued at
// issue time and retired by monitors watching pix_valid_o and busy.
module tb_bean_render;

  logic          clk = 1'b0;
  logic          rst;
  logic [1199:0] beans;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic          pix_valid;
  logic          frame_start;
  logic          bean_on;
  logic [11:0]   bean_rgb;
  logic          pix_valid_o;
  logic [10:0]   remaining;
  logic          cnt_valid;
  logic          all_clear;
  logic          busy;

  bean_render dut (
    .clk         (clk),
    .rst         (rst),
    .beans       (beans),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .bean_on     (bean_on),
    .bean_rgb    (bean_rgb),
    .pix_valid_o (pix_valid_o),
    .remaining   (remaining),
    .cnt_valid   (cnt_valid),
    .all_clear   (all_clear),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   issue;
    logic on;
  } pix_exp_t;

  typedef struct {
    int issue;
    int count;
  } scan_exp_t;

  pix_exp_t  pq[$];
  scan_exp_t sq[$];
  int        cyc = 0;
  int        compared = 0;
  int        mismatched = 0;
  logic      scan_abort = 1'b0;
  logic      prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: dot centred at tile offset (8,8), radius^2 = 9.
  function automatic logic model_on(input logic [1199:0] m, input int x, input int y);
    int idx, dx, dy;
    if (x >= 640 || y >= 480) return 1'b0;
    idx = (y / 16) * 40 + (x / 16);
    dx  = (x % 16) - 8;
    dy  = (y % 16) - 8;
    return m[idx] && (dx * dx + dy * dy <= 9);
  endfunction

  always begin
    pix_exp_t  pe;
    scan_exp_t se;
    @(posedge clk);
    #1;
    if (pix_valid_o === 1'b1) begin
      if (pq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pix_unexpected: pix_valid_o=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        pe = pq.pop_front();
        chk("pix_latency", cyc - pe.issue, 3);
        chk("bean_on", {31'b0, bean_on}, {31'b0, pe.on});
        chk("bean_rgb", {20'b0, bean_rgb}, pe.on ? 32'hFF0 : 32'h0);
      end
    end else begin
      chk("pix_idle_out", {19'b0, bean_on, bean_rgb}, 32'h0);
    end

    if (scan_abort) begin
      chk("abort_outs", {20'b0, remaining, cnt_valid, all_clear, busy}, 32'h0);
      sq.delete();
      scan_abort = 1'b0;
    end else if (busy && !prev_busy) begin
      if (sq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scan_unexpected: busy rose with no accepted frame_start (cycle %0d)", cyc);
      end else begin
        chk("busy_rise_cycle", cyc, sq[0].issue + 1);
      end
    end else if (!busy && prev_busy) begin
      if (sq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scan_result_unexpected: busy fell with nothing outstanding (cycle %0d)", cyc);
      end else begin
        se = sq.pop_front();
        chk("result_cycle", cyc, se.issue + 1202);
        chk("remaining", {21'b0, remaining}, se.count);
        chk("cnt_valid", {31'b0, cnt_valid}, 32'd1);
        chk("all_clear", {31'b0, all_clear}, (se.count == 0) ? 32'd1 : 32'd0);
      end
    end
    prev_busy = busy;
  end

  task automatic drive_pix(input int x, input int y, input logic v);
    @(negedge clk);
    pix_x     = x[9:0];
    pix_y     = y[8:0];
    pix_valid = v;
    if (v) pq.push_back('{issue: cyc, on: model_on(beans, x, y)});
  endtask

  task automatic drain_pix();
    for (int i = 0; i < 5; i++) drive_pix(0, 0, 1'b0);
  endtask

  task automatic pulse_fs(input logic accepted, output int t);
    @(negedge clk);
    frame_start = 1'b1;
    t = cyc;
    if (accepted) sq.push_back('{issue: cyc, count: $countones(beans)});
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_scan();
    int n = 0;
    while (sq.size() != 0 && n < 1400) begin
      @(negedge clk);
      n++;
    end
    if (sq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scan_timeout: result not seen after %0d cycles", n);
      sq.delete();
    end
  endtask

  task automatic random_map(input int n);
    beans = '0;
    while ($countones(beans) < n) begin
      int k = $urandom_range(1199, 0);
      beans[k] = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tdummy;
    rst = 1'b1; beans = '0; pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {6'b0, bean_on, bean_rgb, pix_valid_o, remaining, cnt_valid, all_clear, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single bean at row 2, col 2; dot boundary probes
    beans = '0;
    beans[82] = 1'b1;
    drive_pix(40, 40, 1'b1);
    drive_pix(32, 32, 1'b1);
    drive_pix(43, 40, 1'b1);
    drive_pix(44, 40, 1'b1);
    drive_pix(40, 43, 1'b1);
    drive_pix(37, 40, 1'b1);
    drain_pix();

    // full map: off-screen and invalid pixels must stay dark
    beans = '1;
    drive_pix(700, 100, 1'b1);
    drive_pix(40, 40, 1'b0);
    drive_pix(40, 40, 1'b1);
    drive_pix(100, 490, 1'b1);
    drive_pix(639, 479, 1'b1);
    drain_pix();

    // 138-bean map: scan in background while random pixels stream
    random_map(138);
    pulse_fs(1'b1, t0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) == 0) drive_pix($urandom_range(1023, 0), $urandom_range(511, 0), 1'b1);
      else drive_pix(($urandom_range(39, 0) * 16) + $urandom_range(15, 0),
                     ($urandom_range(29, 0) * 16) + $urandom_range(15, 0),
                     $urandom_range(7, 0) != 0);
    end
    drain_pix();
    wait_scan();

    // empty map
    beans = '0;
    pulse_fs(1'b1, t0);
    wait_scan();

    // retriggers during SCAN and DONE are dropped
    random_map($urandom_range(1199, 1));
    pulse_fs(1'b1, t0);
    wait_until(t0 + 499);
    pulse_fs(1'b0, tdummy);
    chk("retrig_mid_t", tdummy, t0 + 500);
    wait_until(t0 + 1200);
    pulse_fs(1'b0, tdummy);
    chk("retrig_done_t", tdummy, t0 + 1201);
    wait_scan();
    repeat (20) @(negedge clk);
    chk("no_second_scan", {31'b0, busy}, 32'd0);

    // reset mid-scan aborts, then a fresh scan completes
    random_map(600);
    pulse_fs(1'b1, t0);
    wait_until(t0 + 599);
    @(negedge clk);
    rst = 1'b1;
    scan_abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_seen", {31'b0, scan_abort}, 32'd0);
    random_map(1);
    pulse_fs(1'b1, t0);
    wait_scan();

    // random pixels over a dense random map
    random_map(900);
    for (int i = 0; i < 300; i++)
      drive_pix($urandom_range(1023, 0), $urandom_range(511, 0), $urandom_range(9, 0) != 0);
    drain_pix();

    chk("pix_queue_empty", pq.size(), 0);
    chk("scan_queue_empty", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
